// File: rtl/fc_topk_selector.sv
// Streaming top-K logit selector: keeps a sorted table of the K largest logits of a frame
// and holds the ranked result after frame_end until the next clear.
module fc_topk_selector #(
  parameter int unsigned K           = 5,
  parameter int unsigned IDX_W       = 11,
  parameter int unsigned LOGIT_W     = 8,
  parameter int unsigned NUM_CLASSES = 1000
) (
  input  logic                 CLK,
  input  logic                 RESETn,
  input  logic                 clear,
  input  logic                 in_valid,
  input  logic [IDX_W-1:0]     in_class_idx,
  input  logic [LOGIT_W-1:0]   in_logit,
  input  logic                 frame_end,
  output logic                 busy,
  output logic                 result_valid,
  output logic [K*IDX_W-1:0]   top_idx,
  output logic [K*LOGIT_W-1:0] top_logit,
  output logic [3:0]           top_fill,
  output logic [IDX_W-1:0]     class_count,
  output logic                 count_err,
  output logic                 overrun
);

  localparam logic [IDX_W-1:0]   EMPTY_IDX   = '1;
  localparam logic [LOGIT_W-1:0] EMPTY_LOGIT = {1'b1, {(LOGIT_W-1){1'b0}}};
  localparam logic [IDX_W-1:0]   COUNT_MAX   = '1;

  typedef enum logic [1:0] {S_IDLE, S_COLLECT, S_HOLD} state_t;

  state_t               state_q, state_d;
  logic [IDX_W-1:0]     idx_q   [K];
  logic [IDX_W-1:0]     idx_d   [K];
  logic [LOGIT_W-1:0]   logit_q [K];
  logic [LOGIT_W-1:0]   logit_d [K];
  logic [K-1:0]         vld_q, vld_d;
  logic [3:0]           fill_q, fill_d;
  logic [IDX_W-1:0]     count_q, count_d;
  logic                 overrun_q, overrun_d;

  logic [IDX_W-1:0]     base_idx   [K];
  logic [LOGIT_W-1:0]   base_logit [K];
  logic [K-1:0]         base_vld;
  logic [K-1:0]         gt, place, shift;
  logic [3:0]           base_fill;
  logic [IDX_W-1:0]     base_count;
  logic                 collect, ins;

  // State register
  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) state_q <= S_IDLE;
    else         state_q <= state_d;
  end

  // Next-state logic; clear takes priority from any state
  always_comb begin
    state_d = state_q;
    if (clear)                                     state_d = S_COLLECT;
    else if (state_q == S_COLLECT && frame_end)    state_d = S_HOLD;
  end

  // Outputs are decoded from registered state and table only
  always_comb begin
    busy         = (state_q == S_COLLECT);
    result_valid = (state_q == S_HOLD);
    count_err    = (state_q == S_HOLD) && (count_q != IDX_W'(NUM_CLASSES));
    top_fill     = fill_q;
    class_count  = count_q;
    overrun      = overrun_q;
    top_idx      = '0;
    top_logit    = '0;
    for (int r = 0; r < int'(K); r++) begin
      top_idx[r*IDX_W +: IDX_W]       = idx_q[r];
      top_logit[r*LOGIT_W +: LOGIT_W] = logit_q[r];
    end
  end

  // Insertion: a clear first empties the table so a same-cycle sample lands in rank 0.
  // The table stays sorted, so gt is a thermometer code and its lowest set bit is the slot.
  always_comb begin
    collect    = (state_q == S_COLLECT);
    ins        = in_valid && (clear || collect);
    base_fill  = clear ? 4'd0 : fill_q;
    base_count = clear ? '0 : count_q;
    for (int r = 0; r < int'(K); r++) begin
      base_vld[r]   = vld_q[r] & ~clear;
      base_idx[r]   = clear ? EMPTY_IDX : idx_q[r];
      base_logit[r] = clear ? EMPTY_LOGIT : logit_q[r];
      gt[r]         = !base_vld[r] || ($signed(in_logit) > $signed(base_logit[r]));
    end
    place = ins ? (gt & ~K'(gt << 1)) : '0;
    shift = ins ? K'(gt << 1) : '0;

    vld_d = base_vld;
    for (int r = 0; r < int'(K); r++) begin
      idx_d[r]   = base_idx[r];
      logit_d[r] = base_logit[r];
      if (place[r]) begin
        idx_d[r]   = in_class_idx;
        logit_d[r] = in_logit;
        vld_d[r]   = 1'b1;
      end
    end
    for (int r = 1; r < int'(K); r++) begin
      if (shift[r]) begin
        idx_d[r]   = base_idx[r-1];
        logit_d[r] = base_logit[r-1];
        vld_d[r]   = base_vld[r-1];
      end
    end

    fill_d    = (ins && base_fill < 4'(K)) ? base_fill + 4'd1 : base_fill;
    count_d   = (ins && base_count != COUNT_MAX) ? base_count + IDX_W'(1) : base_count;
    overrun_d = clear ? 1'b0 : (overrun_q | (in_valid && !collect));
  end

  // Table and counters
  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      for (int r = 0; r < int'(K); r++) begin
        idx_q[r]   <= EMPTY_IDX;
        logit_q[r] <= EMPTY_LOGIT;
      end
      vld_q     <= '0;
      fill_q    <= 4'd0;
      count_q   <= '0;
      overrun_q <= 1'b0;
    end else begin
      for (int r = 0; r < int'(K); r++) begin
        idx_q[r]   <= idx_d[r];
        logit_q[r] <= logit_d[r];
      end
      vld_q     <= vld_d;
      fill_q    <= fill_d;
      count_q   <= count_d;
      overrun_q <= overrun_d;
    end
  end

endmodule

// File: tb/tb_fc_topk_selector.sv
// Self-checking bench for fc_topk_selector: directed and random frames against a
// frame-level model that ranks all samples of the frame by a stable selection.
module tb_fc_topk_selector;
  localparam int unsigned K = 5, IDX_W = 11, LOGIT_W = 8, NUM_CLASSES = 1000;

  logic CLK = 1'b0, RESETn = 1'b0, clear = 1'b0, in_valid = 1'b0, frame_end = 1'b0;
  logic [IDX_W-1:0]     in_class_idx = '0;
  logic [LOGIT_W-1:0]   in_logit = '0;
  logic                 busy, result_valid, count_err, overrun;
  logic [K*IDX_W-1:0]   top_idx;
  logic [K*LOGIT_W-1:0] top_logit;
  logic [3:0]           top_fill;
  logic [IDX_W-1:0]     class_count;

  fc_topk_selector #(.K(K), .IDX_W(IDX_W), .LOGIT_W(LOGIT_W), .NUM_CLASSES(NUM_CLASSES)) dut (
    .CLK(CLK), .RESETn(RESETn), .clear(clear), .in_valid(in_valid),
    .in_class_idx(in_class_idx), .in_logit(in_logit), .frame_end(frame_end),
    .busy(busy), .result_valid(result_valid), .top_idx(top_idx), .top_logit(top_logit),
    .top_fill(top_fill), .class_count(class_count), .count_err(count_err), .overrun(overrun)
  );

  always #5 CLK = ~CLK;

  typedef struct { logic [IDX_W-1:0] idx; logic signed [LOGIT_W-1:0] lg; } samp_t;

  int n_checks = 0, n_fail = 0;
  int m_mode;   // 0 idle, 1 collect, 2 hold
  int m_count;
  bit m_over;
  samp_t q[$];
  logic [K*IDX_W-1:0]   e_idx;
  logic [K*LOGIT_W-1:0] e_lg;
  int e_fill;

  function automatic void model_reset();
    m_mode = 0; m_count = 0; m_over = 0; q.delete();
  endfunction

  // Rank the whole frame: repeatedly take the largest remaining, earliest on ties
  function automatic void model_top();
    bit used[];
    used = new[q.size()];
    e_fill = (q.size() < int'(K)) ? q.size() : int'(K);
    for (int r = 0; r < int'(K); r++) begin
      int best = -1;
      for (int j = 0; j < q.size(); j++)
        if (!used[j] && (best < 0 || q[j].lg > q[best].lg)) best = j;
      if (best >= 0) begin
        used[best] = 1'b1;
        e_idx[r*IDX_W +: IDX_W]   = q[best].idx;
        e_lg[r*LOGIT_W +: LOGIT_W] = q[best].lg;
      end else begin
        e_idx[r*IDX_W +: IDX_W]   = '1;
        e_lg[r*LOGIT_W +: LOGIT_W] = 8'h80;
      end
    end
  endfunction

  // One clock cycle of stimulus, mirrored into the model
  task automatic drive(input bit c, input bit v, input int idx, input int lg, input bit fe);
    samp_t s;
    clear = c; in_valid = v; in_class_idx = IDX_W'(idx); in_logit = LOGIT_W'(lg); frame_end = fe;
    s.idx = IDX_W'(idx); s.lg = LOGIT_W'(lg);
    if (c) begin
      q.delete(); m_count = 0; m_over = 0; m_mode = 1;
      if (v) begin q.push_back(s); m_count = 1; end
    end else if (m_mode == 1) begin
      if (v) begin q.push_back(s); if (m_count < 2047) m_count++; end
      if (fe) m_mode = 2;
    end else if (v) m_over = 1;
    @(posedge CLK); #1;
    clear = 1'b0; in_valid = 1'b0; frame_end = 1'b0;
  endtask

  task automatic test_reset();
    model_top();
    n_checks++; if (busy !== 1'b0 || result_valid !== 1'b0) begin n_fail++; $display("FAIL reset_flags: got busy=%b rv=%b expected 0 0", busy, result_valid); end
    n_checks++; if (top_idx !== {K{11'h7FF}}) begin n_fail++; $display("FAIL reset_idx: got %h expected all ones", top_idx); end
    n_checks++; if (top_logit !== {K{8'h80}}) begin n_fail++; $display("FAIL reset_logit: got %h expected %h", top_logit, {K{8'h80}}); end
    n_checks++; if (top_fill !== 4'd0 || class_count !== '0 || count_err !== 1'b0 || overrun !== 1'b0) begin n_fail++; $display("FAIL reset_counters: got fill=%0d cnt=%0d err=%b ovr=%b expected 0", top_fill, class_count, count_err, overrun); end
  endtask

  task automatic test_idle_overrun();
    drive(0, 1, 5, 50, 0);
    n_checks++; if (overrun !== 1'b1 || top_fill !== 4'd0 || class_count !== '0) begin n_fail++; $display("FAIL idle_overrun: got ovr=%b fill=%0d cnt=%0d expected 1 0 0", overrun, top_fill, class_count); end
    drive(0, 0, 0, 0, 1);
    n_checks++; if (result_valid !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL idle_frame_end: got rv=%b busy=%b expected 0 0", result_valid, busy); end
  endtask

  task automatic test_ramp();
    logic [K*IDX_W-1:0] xi; logic [K*LOGIT_W-1:0] xl;
    drive(1, 0, 0, 0, 0);
    n_checks++; if (busy !== 1'b1 || overrun !== 1'b0) begin n_fail++; $display("FAIL ramp_clear: got busy=%b ovr=%b expected 1 0", busy, overrun); end
    for (int i = 0; i < 10; i++) drive(0, 1, i, i, 0);
    drive(0, 0, 0, 0, 1);
    for (int r = 0; r < int'(K); r++) begin xi[r*IDX_W +: IDX_W] = IDX_W'(9 - r); xl[r*LOGIT_W +: LOGIT_W] = LOGIT_W'(9 - r); end
    n_checks++; if (top_idx !== xi || top_logit !== xl) begin n_fail++; $display("FAIL ramp_top: got %h/%h expected %h/%h", top_idx, top_logit, xi, xl); end
    n_checks++; if (result_valid !== 1'b1 || top_fill !== 4'd5 || class_count !== 11'd10 || count_err !== 1'b1) begin n_fail++; $display("FAIL ramp_status: got rv=%b fill=%0d cnt=%0d err=%b expected 1 5 10 1", result_valid, top_fill, class_count, count_err); end
  endtask

  task automatic test_ties();
    drive(1, 0, 0, 0, 0);
    drive(0, 1, 3, 7, 0);
    drive(0, 1, 8, 7, 0);
    drive(0, 0, 0, 0, 1);
    model_top();
    n_checks++; if (top_idx[10:0] !== 11'd3 || top_idx[21:11] !== 11'd8) begin n_fail++; $display("FAIL ties_order: got r0=%0d r1=%0d expected 3 8", top_idx[10:0], top_idx[21:11]); end
    n_checks++; if (top_idx !== e_idx || top_logit !== e_lg || top_fill !== 4'd2) begin n_fail++; $display("FAIL ties_table: got %h/%h fill=%0d expected %h/%h fill=2", top_idx, top_logit, top_fill, e_idx, e_lg); end
  endtask

  task automatic test_min_logit();
    drive(1, 0, 0, 0, 0);
    drive(0, 1, 0, -128, 0);
    drive(0, 0, 0, 0, 1);
    n_checks++; if (top_idx[10:0] !== 11'd0 || top_logit[7:0] !== 8'h80 || top_fill !== 4'd1) begin n_fail++; $display("FAIL min_logit: got idx=%0d lg=%h fill=%0d expected 0 80 1", top_idx[10:0], top_logit[7:0], top_fill); end
  endtask

  task automatic test_max_last();
    drive(1, 0, 0, 0, 0);
    for (int i = 0; i < 5; i++) drive(0, 1, 20 + i, 10 + i, 0);
    drive(0, 1, 77, 127, 0);
    drive(0, 0, 0, 0, 1);
    model_top();
    n_checks++; if (top_idx[10:0] !== 11'd77 || top_logit[7:0] !== 8'd127 || top_logit[39:32] !== 8'd11) begin n_fail++; $display("FAIL max_last: got r0=%0d/%0d r4lg=%0d expected 77/127 11", top_idx[10:0], top_logit[7:0], top_logit[39:32]); end
    n_checks++; if (top_idx !== e_idx || top_logit !== e_lg) begin n_fail++; $display("FAIL max_last_table: got %h/%h expected %h/%h", top_idx, top_logit, e_idx, e_lg); end
  endtask

  task automatic test_valid_with_frame_end();
    drive(1, 0, 0, 0, 0);
    drive(0, 1, 1, -5, 0);
    drive(0, 1, 2, 30, 0);
    drive(0, 1, 3, 60, 1);
    model_top();
    n_checks++; if (result_valid !== 1'b1 || class_count !== 11'd3 || top_idx[10:0] !== 11'd3) begin n_fail++; $display("FAIL valid_fe: got rv=%b cnt=%0d r0=%0d expected 1 3 3", result_valid, class_count, top_idx[10:0]); end
    n_checks++; if (top_idx !== e_idx || top_logit !== e_lg || top_fill !== 4'(e_fill)) begin n_fail++; $display("FAIL valid_fe_table: got %h/%h expected %h/%h", top_idx, top_logit, e_idx, e_lg); end
  endtask

  task automatic test_hold_overrun();
    drive(0, 1, 9, 127, 0);
    drive(0, 0, 0, 0, 1);
    model_top();
    n_checks++; if (top_idx !== e_idx || top_logit !== e_lg || class_count !== 11'd3) begin n_fail++; $display("FAIL hold_frozen: got %h/%h cnt=%0d expected %h/%h cnt=3", top_idx, top_logit, class_count, e_idx, e_lg); end
    n_checks++; if (overrun !== 1'b1 || result_valid !== 1'b1) begin n_fail++; $display("FAIL hold_overrun: got ovr=%b rv=%b expected 1 1", overrun, result_valid); end
  endtask

  task automatic test_clear_with_valid();
    drive(1, 1, 42, -3, 0);
    n_checks++; if (class_count !== 11'd1 || overrun !== 1'b0 || busy !== 1'b1 || top_fill !== 4'd1) begin n_fail++; $display("FAIL clr_valid_status: got cnt=%0d ovr=%b busy=%b fill=%0d expected 1 0 1 1", class_count, overrun, busy, top_fill); end
    n_checks++; if (top_idx[10:0] !== 11'd42 || top_logit[7:0] !== 8'hFD || top_idx[21:11] !== 11'h7FF) begin n_fail++; $display("FAIL clr_valid_rank0: got %0d/%h r1=%h expected 42/fd 7ff", top_idx[10:0], top_logit[7:0], top_idx[21:11]); end
  endtask

  task automatic test_random_frame();
    drive(1, 0, 0, 0, 0);
    for (int i = 0; i < int'(NUM_CLASSES); i++) begin
      int lg;
      lg = (i % 2 == 1) ? int'($urandom_range(0, 255)) : int'($urandom_range(100, 115));
      drive(0, 1, int'($urandom_range(0, 2047)), lg, i == int'(NUM_CLASSES) - 1);
      if (i % 250 == 125) begin
        model_top();
        n_checks++; if (top_idx !== e_idx || top_logit !== e_lg || busy !== 1'b1) begin n_fail++; $display("FAIL rand_mid_%0d: got %h/%h expected %h/%h", i, top_idx, top_logit, e_idx, e_lg); end
      end
    end
    model_top();
    n_checks++; if (top_idx !== e_idx || top_logit !== e_lg) begin n_fail++; $display("FAIL rand_final: got %h/%h expected %h/%h", top_idx, top_logit, e_idx, e_lg); end
    n_checks++; if (result_valid !== 1'b1 || count_err !== 1'b0 || class_count !== 11'(NUM_CLASSES) || top_fill !== 4'd5) begin n_fail++; $display("FAIL rand_status: got rv=%b err=%b cnt=%0d fill=%0d expected 1 0 1000 5", result_valid, count_err, class_count, top_fill); end
  endtask

  task automatic test_saturate();
    drive(1, 0, 0, 0, 0);
    for (int i = 0; i < 2100; i++) drive(0, 1, i % 2048, int'($urandom_range(0, 255)), 0);
    drive(0, 0, 0, 0, 1);
    model_top();
    n_checks++; if (class_count !== 11'(m_count) || count_err !== 1'b1) begin n_fail++; $display("FAIL saturate: got cnt=%0d err=%b expected %0d 1", class_count, count_err, m_count); end
    n_checks++; if (top_idx !== e_idx || top_logit !== e_lg) begin n_fail++; $display("FAIL saturate_table: got %h/%h expected %h/%h", top_idx, top_logit, e_idx, e_lg); end
  endtask

  task automatic test_reset_midframe();
    drive(1, 1, 4, 20, 0);
    drive(0, 1, 5, 40, 0);
    drive(0, 1, 6, 30, 0);
    #2 RESETn = 1'b0; model_reset();
    #1;
    n_checks++; if (busy !== 1'b0 || top_fill !== 4'd0 || class_count !== '0 || top_idx !== {K{11'h7FF}} || top_logit !== {K{8'h80}}) begin n_fail++; $display("FAIL reset_mid: got busy=%b fill=%0d cnt=%0d idx=%h expected idle/empty", busy, top_fill, class_count, top_idx); end
    #3 RESETn = 1'b1;
    @(posedge CLK); #1;
    drive(0, 0, 0, 0, 1);
    n_checks++; if (result_valid !== 1'b0 || busy !== 1'b0 || count_err !== 1'b0) begin n_fail++; $display("FAIL reset_mid_fe: got rv=%b busy=%b err=%b expected 0 0 0", result_valid, busy, count_err); end
  endtask

  initial begin
    model_reset();
    repeat (2) @(posedge CLK);
    #1 RESETn = 1'b1;
    @(posedge CLK); #1;
    test_reset();
    test_idle_overrun();
    test_ramp();
    test_ties();
    test_min_logit();
    test_max_last();
    test_valid_with_frame_end();
    test_hold_overrun();
    test_clear_with_valid();
    test_random_frame();
    test_saturate();
    test_reset_midframe();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
